coin_change_dispenser: RTL and testbench

- Payout end of the vending machine coin path. The vending core computes a change amount in cents. This block accepts that amount over a valid/ready handshake and drives the quarter, dime and nickel hopper solenoids one coin at a time.
- After each eject pulse it waits for the exit-chute sensor to confirm the coin, tracks per-hopper inventory, and reports the coins paid, any shortfall, and jam faults back to the core.

---
 rtl/coin_change_dispenser.sv | 186 ++++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - greedy quarter/dime/nickel change payout with
// per-coin exit-sensor confirmation, hopper inventory tracking and jam detection.
module coin_change_dispenser #(
  parameter int TIMEOUT = 1000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [8:0] change_amt,
  input  logic       load_inv,
  input  logic [4:0] inv_q_in,
  input  logic [4:0] inv_d_in,
  input  logic [4:0] inv_n_in,
  input  logic       coin_seen,
  input  logic       clear_fault,
  output logic       eject_q,
  output logic       eject_d,
  output logic       eject_n,
  output logic       busy,
  output logic       done,
  output logic [4:0] disp_q,
  output logic [4:0] disp_d,
  output logic [4:0] disp_n,
  output logic [8:0] shortfall,
  output logic       jam,
  output logic [4:0] inv_q,
  output logic [4:0] inv_d,
  output logic [4:0] inv_n
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECT     = 3'd1,
    EJECT      = 3'd2,
    WAIT_SENSE = 3'd3,
    DONE       = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam logic [1:0] COIN_Q = 2'd0;
  localparam logic [1:0] COIN_D = 2'd1;
  localparam logic [1:0] COIN_N = 2'd2;

  // Timer holds TIMEOUT-2 in the last waiting cycle, so jam rises TIMEOUT cycles after the eject.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t        state, next_state;
  logic [1:0]    sel, pick;
  logic          pick_ok;
  logic [8:0]    remaining;
  logic [8:0]    coin_val;
  logic [TW-1:0] timer;
  logic          accept;
  logic          expired;

  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign expired = (timer == T_LAST);

  always_comb begin
    pick_ok = 1'b1;
    pick    = COIN_Q;
    if (remaining >= 9'd25 && inv_q != 5'd0) begin
      pick = COIN_Q;
    end else if (remaining >= 9'd10 && inv_d != 5'd0) begin
      pick = COIN_D;
    end else if (remaining >= 9'd5 && inv_n != 5'd0) begin
      pick = COIN_N;
    end else begin
      pick_ok = 1'b0;
    end
  end

  always_comb begin
    coin_val = 9'd5;
    case (sel)
      COIN_Q:  coin_val = 9'd25;
      COIN_D:  coin_val = 9'd10;
      default: coin_val = 9'd5;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (accept) next_state = SELECT;
      SELECT:     next_state = pick_ok ? EJECT : DONE;
      EJECT:      next_state = WAIT_SENSE;
      WAIT_SENSE: begin
        if (coin_seen) next_state = SELECT;
        else if (expired) next_state = FAULT;
      end
      DONE:       next_state = IDLE;
      FAULT:      if (clear_fault) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Status outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      jam       <= 1'b0;
      eject_q   <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
    end else begin
      req_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      done      <= (next_state == DONE);
      jam       <= (next_state == FAULT);
      eject_q   <= (next_state == EJECT) && (pick == COIN_Q);
      eject_d   <= (next_state == EJECT) && (pick == COIN_D);
      eject_n   <= (next_state == EJECT) && (pick == COIN_N);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= COIN_Q;
      remaining <= 9'd0;
      timer     <= '0;
      disp_q    <= 5'd0;
      disp_d    <= 5'd0;
      disp_n    <= 5'd0;
      shortfall <= 9'd0;
      inv_q     <= 5'd0;
      inv_d     <= 5'd0;
      inv_n     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= change_amt;
            disp_q    <= 5'd0;
            disp_d    <= 5'd0;
            disp_n    <= 5'd0;
            shortfall <= 9'd0;
          end else if (load_inv && !req_valid) begin
            inv_q <= inv_q_in;
            inv_d <= inv_d_in;
            inv_n <= inv_n_in;
          end
        end
        SELECT: begin
          if (pick_ok) sel <= pick;
          else         shortfall <= remaining;
        end
        EJECT: timer <= '0;
        WAIT_SENSE: begin
          timer <= timer + T_ONE;
          if (coin_seen) begin
            remaining <= remaining - coin_val;
            case (sel)
              COIN_Q: begin
                inv_q  <= inv_q - 5'd1;
                disp_q <= disp_q + 5'd1;
              end
              COIN_D: begin
                inv_d  <= inv_d - 5'd1;
                disp_d <= disp_d + 5'd1;
              end
              default: begin
                inv_n  <= inv_n - 5'd1;
                disp_n <= disp_n + 5'd1;
              end
            endcase
          end else if (expired) begin
            shortfall <= remaining;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb/tb_coin_change_dispenser.sv - randomized scoreboard bench for coin_change_dispenser
// against a greedy payout reference model.
module tb_coin_change_dispenser;
  localparam int TIMEOUT = 40;
  localparam int TW      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [8:0] change_amt;
  logic       load_inv;
  logic [4:0] inv_q_in, inv_d_in, inv_n_in;
  logic       coin_seen, clear_fault;
  logic       eject_q, eject_d, eject_n;
  logic       busy, done, jam;
  logic [4:0] disp_q, disp_d, disp_n;
  logic [8:0] shortfall;
  logic [4:0] inv_q, inv_d, inv_n;

  coin_change_dispenser #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .change_amt(change_amt), .load_inv(load_inv), .inv_q_in(inv_q_in),
    .inv_d_in(inv_d_in), .inv_n_in(inv_n_in), .coin_seen(coin_seen),
    .clear_fault(clear_fault), .eject_q(eject_q), .eject_d(eject_d),
    .eject_n(eject_n), .busy(busy), .done(done), .disp_q(disp_q),
    .disp_d(disp_d), .disp_n(disp_n), .shortfall(shortfall), .jam(jam),
    .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dq, dd, dn, sf, ivq, ivd, ivn;
    bit jm;
  } res_t;

  res_t exp_res[$];
  int   exp_ej[$];
  res_t last_res;
  res_t mon_r;
  int   mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycles = 0;
  int   mq = 0, md = 0, mn = 0;
  bit   jam_prev = 1'b0;

  always @(posedge clk) cycles <= cycles + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: greedy payout on plain integers; the coin with index jam_at is ejected but never confirmed.
  task automatic model(input int amt, input int jam_at);
    res_t r;
    int rem, k, c;
    r = '{default: 0};
    rem = amt;
    k = 0;
    forever begin
      c = -1;
      if (rem >= 25 && mq > 0) c = 0;
      else if (rem >= 10 && md > 0) c = 1;
      else if (rem >= 5 && mn > 0) c = 2;
      if (c < 0) break;
      exp_ej.push_back(c);
      if (k == jam_at) begin
        r.jm = 1'b1;
        break;
      end
      case (c)
        0: begin mq--; r.dq++; rem -= 25; end
        1: begin md--; r.dd++; rem -= 10; end
        default: begin mn--; r.dn++; rem -= 5; end
      endcase
      k++;
    end
    r.sf = rem;
    r.ivq = mq;
    r.ivd = md;
    r.ivn = mn;
    exp_res.push_back(r);
    last_res = r;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (eject_q || eject_d || eject_n) begin
        chk("eject_onehot", int'(eject_q) + int'(eject_d) + int'(eject_n), 1);
        if (exp_ej.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_eject: got q%0d d%0d n%0d expected none", eject_q, eject_d, eject_n);
        end else begin
          mon_e = exp_ej.pop_front();
          chk("eject_coin", eject_q ? 0 : (eject_d ? 1 : 2), mon_e);
        end
      end
      if (done || (jam && !jam_prev)) begin
        if (exp_res.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_end: got done=%0d jam=%0d expected no completion", done, jam);
        end else begin
          mon_r = exp_res.pop_front();
          chk("end_is_jam", int'(jam), int'(mon_r.jm));
          chk("end_done", int'(done), int'(!mon_r.jm));
          chk("disp_q", disp_q, mon_r.dq);
          chk("disp_d", disp_d, mon_r.dd);
          chk("disp_n", disp_n, mon_r.dn);
          chk("shortfall", shortfall, mon_r.sf);
          chk("inv_q", inv_q, mon_r.ivq);
          chk("inv_d", inv_d, mon_r.ivd);
          chk("inv_n", inv_n, mon_r.ivn);
        end
      end
      jam_prev = jam;
    end else begin
      jam_prev = 1'b0;
    end
  end

  task automatic wait_ready();
    int g;
    g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_jam", jam, 0);
    chk("rst_eject", int'(eject_q) + int'(eject_d) + int'(eject_n), 0);
    chk("rst_disp", int'(disp_q) + int'(disp_d) + int'(disp_n), 0);
    chk("rst_shortfall", shortfall, 0);
    chk("rst_inv", int'(inv_q) + int'(inv_d) + int'(inv_n), 0);
  endtask

  task automatic do_load(input int q, input int d, input int n);
    wait_ready();
    load_inv = 1'b1;
    inv_q_in = 5'(q);
    inv_d_in = 5'(d);
    inv_n_in = 5'(n);
    @(negedge clk);
    load_inv = 1'b0;
    mq = q;
    md = d;
    mn = n;
  endtask

  // dmode 1 confirms every coin in the final cycle of the sensor window.
  task automatic run_req(input int amt, input int jam_at, input int dmode);
    int acc, guard, nej, d, r;
    bit fin;
    model(amt, jam_at);
    wait_ready();
    req_valid = 1'b1;
    change_amt = 9'(amt);
    @(negedge clk);
    req_valid = 1'b0;
    acc = cycles;
    guard = 0;
    nej = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_timeout: got no completion after %0d cycles expected done or jam", guard);
        fin = 1'b1;
      end else if (done) begin
        if (nej == 0) chk("done_latency", cycles - acc + 1, 2);
        fin = 1'b1;
      end else if (jam) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_jam: got jam=1 expected coin %0d confirmed", nej);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        fin = 1'b1;
      end else if (eject_q || eject_d || eject_n) begin
        if (nej == 0) chk("first_eject_latency", cycles - acc + 1, 2);
        if (nej == jam_at) begin
          repeat (TIMEOUT - 1) @(negedge clk);
          chk("jam_before_timeout", jam, 0);
          @(negedge clk);
          chk("jam_at_timeout", jam, 1);
          clear_fault = 1'b1;
          @(negedge clk);
          clear_fault = 1'b0;
          chk("ready_after_clear", req_ready, 1);
          chk("busy_after_clear", busy, 0);
          fin = 1'b1;
        end else begin
          r = $urandom % 4;
          if (dmode == 1 || r == 1) d = TIMEOUT - 1;
          else if (r == 0) d = 1;
          else d = $urandom_range(1, TIMEOUT - 1);
          repeat (d) @(negedge clk);
          coin_seen = 1'b1;
          load_inv = 1'b1;
          inv_q_in = 5'd31;
          inv_d_in = 5'd31;
          inv_n_in = 5'd31;
          @(negedge clk);
          coin_seen = 1'b0;
          load_inv = 1'b0;
        end
        nej++;
      end
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int amt, ja, g;
    rst = 1'b1;
    req_valid = 1'b0;
    change_amt = '0;
    load_inv = 1'b0;
    inv_q_in = '0;
    inv_d_in = '0;
    inv_n_in = '0;
    coin_seen = 1'b0;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    check_reset_values();

    do_load(4, 4, 4);
    run_req(40, -1, 0);
    do_load(0, 5, 1);
    run_req(30, -1, 0);
    run_req(7, -1, 0);
    run_req(0, -1, 0);
    do_load(2, 0, 0);
    run_req(50, 1, 0);
    do_load(3, 3, 3);
    run_req(65, -1, 1);

    wait_ready();
    coin_seen = 1'b1;
    repeat (2) @(negedge clk);
    coin_seen = 1'b0;
    @(negedge clk);
    chk("idle_seen_inv_q", inv_q, mq);
    chk("idle_seen_inv_d", inv_d, md);
    chk("idle_seen_inv_n", inv_n, mn);
    chk("idle_seen_disp_q", disp_q, last_res.dq);
    chk("idle_seen_disp_n", disp_n, last_res.dn);
    chk("idle_seen_busy", busy, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom % 3 == 0) begin
        if ($urandom % 5 == 0) do_load(31, 31, 31);
        else do_load($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      end
      amt = ($urandom % 4 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 120);
      ja = ($urandom % 5 == 0) ? $urandom_range(0, 3) : -1;
      run_req(amt, ja, 0);
    end

    do_load(4, 4, 4);
    exp_ej.push_back(0);
    wait_ready();
    req_valid = 1'b1;
    change_amt = 9'd75;
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!(eject_q || eject_d || eject_n) && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("midreset_eject_seen", int'(eject_q), 1);
    repeat (3) @(negedge clk);
    load_inv = 1'b1;
    inv_q_in = 5'd31;
    inv_d_in = 5'd31;
    inv_n_in = 5'd31;
    @(negedge clk);
    load_inv = 1'b0;
    chk("busy_load_ignored_q", inv_q, 4);
    chk("busy_load_ignored_d", inv_d, 4);
    chk("midreset_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    exp_res.delete();
    exp_ej.delete();
    mq = 0;
    md = 0;
    mn = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_req_ready", req_ready, 1);

    do_load(1, 1, 1);
    run_req(40, -1, 0);
    repeat (3) @(negedge clk);
    chk("res_queue_empty", exp_res.size(), 0);
    chk("eject_queue_empty", exp_ej.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
